stream_fifo: RTL and testbench

- Parametrised, depth-buffered successor to the point-to-point stream interfaces (pixelstream, audiostream, bytestream).
- Decouples a stream source from a stream sink with configurable data width and depth.
- Adds level reporting, an almost-full threshold, flush, and sticky overflow/underrun flags.
- Used between CD sector decode, audio mixing and video fetch paths, where producer and consumer burst at different rates.

---
 rtl/stream_pkg.sv | 16 +
 rtl/stream_fifo_if.sv | 22 ++
 rtl/stream_fifo_ram.sv | 26 ++
 rtl/stream_fifo.sv | 130 +++++++++++++
 tb/tb_stream_fifo.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the stream FIFO family: level-width helper,
// empty-output fill encoding and common stream word aliases.
package stream_pkg;

  // Value of SIGNED_ZERO_FILL that forces out_data to 0 while empty.
  localparam bit ZERO_FILL = 1'b1;

  typedef logic [7:0]         byte_t;
  typedef logic signed [15:0] sample_t;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int clog2p1(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_fifo_if.sv
// Source/sink handshake bundle for stream_fifo. The master side is the
// producer/consumer pair, the slave side is the FIFO itself.
interface stream_fifo_if #(
  parameter int WIDTH = 16
) ();
  logic             in_write;
  logic [WIDTH-1:0] in_data;
  logic             in_strobe;
  logic             out_write;
  logic [WIDTH-1:0] out_data;
  logic             out_strobe;

  modport master (
    output in_write, in_data, out_strobe,
    input  in_strobe, out_write, out_data
  );

  modport slave (
    input  in_write, in_data, out_strobe,
    output in_strobe, out_write, out_data
  );
endinterface

// File: rtl/stream_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// The array carries no reset so it maps onto block RAM; a read of the
// address being written in the same cycle returns the old contents.
module stream_fifo_ram #(
  parameter int  WIDTH = 16,
  parameter int  DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO with level, almost-full, flush and
// sticky overflow/underrun. Full/empty come from the level counter.
// The RAM read is registered, so the address presented each cycle is the
// head for the next cycle; a word written in the same cycle it becomes the
// head is forwarded through a bypass register instead of the RAM.
module stream_fifo
  import stream_pkg::*;
#(
  parameter int  WIDTH            = 16,
  parameter int  DEPTH            = 64,
  parameter int  AFULL_LEVEL      = 48,
  parameter bit  SIGNED_ZERO_FILL = 1'b0,
  localparam int AW               = $clog2(DEPTH),
  localparam int LW               = clog2p1(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  stream_fifo_if.slave  s,
  input  logic          flush,
  output logic [LW-1:0] level,
  output logic          almost_full,
  output logic          overflow,
  output logic          underrun
);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("stream_fifo: DEPTH must be a power of two >= 4");
  end
  if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
    $error("stream_fifo: AFULL_LEVEL must be in 1..DEPTH");
  end

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             in_strobe_q, in_strobe_d;
  logic             out_write_q, out_write_d;
  logic             afull_q, afull_d;
  logic             ovf_q, ovf_d, und_q, und_d;
  logic             sel_byp_q, sel_byp_d;
  logic [WIDTH-1:0] byp_q, byp_d, hold_q, ram_rdata, out_data_w;
  logic             push, pop;

  assign push = s.in_write && in_strobe_q;
  assign pop  = s.out_strobe && out_write_q;

  stream_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (push && !flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (s.in_data),
    .raddr_i (rd_ptr_d),
    .rdata_o (ram_rdata)
  );

  // Next-state for pointers, level, flags and the head bypass.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    ovf_d     = ovf_q | (s.in_write & ~in_strobe_q);
    und_d     = und_q | (s.out_strobe & ~out_write_q);
    byp_d     = byp_q;
    sel_byp_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      und_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
      // Pushed word is next cycle's head: RAM would return stale data.
      if (push && level_d == LW'(1)) begin
        sel_byp_d = 1'b1;
        byp_d     = s.in_data;
      end
    end
    in_strobe_d = (level_d != LW'(DEPTH));
    out_write_d = (level_d != '0);
    afull_d     = (level_d >= LW'(AFULL_LEVEL));
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      in_strobe_q <= 1'b1;
      out_write_q <= 1'b0;
      afull_q     <= 1'b0;
      ovf_q       <= 1'b0;
      und_q       <= 1'b0;
      sel_byp_q   <= 1'b0;
      byp_q       <= '0;
      hold_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      in_strobe_q <= in_strobe_d;
      out_write_q <= out_write_d;
      afull_q     <= afull_d;
      ovf_q       <= ovf_d;
      und_q       <= und_d;
      sel_byp_q   <= sel_byp_d;
      byp_q       <= byp_d;
      hold_q      <= out_data_w;
    end
  end

  // Head select; while empty show zero or the last displayed word.
  always_comb begin
    if (out_write_q)                        out_data_w = sel_byp_q ? byp_q : ram_rdata;
    else if (SIGNED_ZERO_FILL == ZERO_FILL) out_data_w = '0;
    else                                    out_data_w = hold_q;
  end

  assign s.in_strobe  = in_strobe_q;
  assign s.out_write  = out_write_q;
  assign s.out_data   = out_data_w;
  assign level        = level_q;
  assign almost_full  = afull_q;
  assign overflow     = ovf_q;
  assign underrun     = und_q;

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo: vector table for the single-entry corners, a queue
// scoreboard with a behavioural level/flag model checked every cycle, and
// hand sequences for fill, flush, wrap, async reset and the zero-fill build.
module tb_stream_fifo;
  import stream_pkg::*;

  localparam int W = 16, D = 64, AF = 48;

  logic       clk, reset_n, flush, zflush;
  logic [6:0] lvl;
  logic       afull, ovf, und;
  logic [2:0] zlvl;
  logic       zafull, zovf, zund;

  stream_fifo_if #(.WIDTH(W)) b ();
  stream_fifo_if #(.WIDTH(W)) z ();

  stream_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_LEVEL(AF), .SIGNED_ZERO_FILL(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .s(b.slave), .flush(flush),
    .level(lvl), .almost_full(afull), .overflow(ovf), .underrun(und)
  );

  stream_fifo #(.WIDTH(W), .DEPTH(4), .AFULL_LEVEL(3), .SIGNED_ZERO_FILL(1'b1)) dut_z (
    .clk(clk), .reset_n(reset_n), .s(z.slave), .flush(zflush),
    .level(zlvl), .almost_full(zafull), .overflow(zovf), .underrun(zund)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks, errors;
  logic [15:0] sb[$];
  int          m_level;
  bit          m_instr, m_ovf, m_und;
  logic [15:0] m_prev;

  typedef struct {
    logic        wr;
    logic [15:0] dat;
    logic        os;
    logic        fl;
    logic        e_ow;
    logic [15:0] e_dat;
    int          e_lvl;
    logic        e_und;
  } vec_t;
  vec_t vec[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    sb.delete();
    m_level = 0;
    m_instr = 1'b1;
    m_ovf   = 1'b0;
    m_und   = 1'b0;
    m_prev  = '0;
  endtask

  task automatic idle();
    b.in_write   = 1'b0;
    b.out_strobe = 1'b0;
    flush        = 1'b0;
  endtask

  // One clock: update the model from the driven inputs, then check all outputs.
  task automatic cyc();
    logic [15:0] disp;
    if (flush) begin
      sb.delete();
      m_ovf = 1'b0;
      m_und = 1'b0;
    end else begin
      if (b.in_write && !m_instr) m_ovf = 1'b1;
      if (b.out_strobe && m_level == 0) m_und = 1'b1;
      if (b.out_strobe && m_level != 0) void'(sb.pop_front());
      if (b.in_write && m_instr) sb.push_back(b.in_data);
    end
    m_level = sb.size();
    m_instr = (m_level != D);
    @(posedge clk);
    #1;
    disp   = (m_level != 0) ? sb[0] : m_prev;
    m_prev = disp;
    chk("m_level",     32'(lvl),        m_level);
    chk("m_in_strobe", b.in_strobe,     m_instr);
    chk("m_out_write", b.out_write,     m_level != 0);
    chk("m_afull",     afull,           m_level >= AF);
    chk("m_overflow",  ovf,             m_ovf);
    chk("m_underrun",  und,             m_und);
    chk("m_out_data",  b.out_data,      disp);
  endtask

  task automatic zcyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //           wr  dat       os  fl  e_ow e_dat     lvl e_und
    vec[0]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b0};
    vec[1]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h1234, 1, 1'b0};
    vec[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 1, 1'b0};
    vec[3]  = '{1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b1, 16'hBEEF, 1, 1'b0};
    vec[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hBEEF, 0, 1'b0};
    vec[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hBEEF, 0, 1'b1};
    vec[6]  = '{1'b1, 16'h0055, 1'b0, 1'b0, 1'b1, 16'h0055, 1, 1'b1};
    vec[7]  = '{1'b1, 16'hAAAA, 1'b1, 1'b1, 1'b0, 16'h0055, 0, 1'b0};
    vec[8]  = '{1'b1, 16'h0777, 1'b0, 1'b0, 1'b1, 16'h0777, 1, 1'b0};
    vec[9]  = '{1'b1, 16'h0888, 1'b0, 1'b0, 1'b1, 16'h0777, 2, 1'b0};
    vec[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0888, 1, 1'b0};
    vec[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0888, 0, 1'b0};

    reset_n = 1'b0;
    idle();
    b.in_data    = '0;
    z.in_write   = 1'b0;
    z.in_data    = '0;
    z.out_strobe = 1'b0;
    zflush       = 1'b0;
    m_reset();
    #22 reset_n = 1'b1;
    #1;
    chk("rst_level",     32'(lvl),   0);
    chk("rst_in_strobe", b.in_strobe, 1);
    chk("rst_out_write", b.out_write, 0);
    chk("rst_out_data",  b.out_data,  0);
    chk("rst_flags",     {afull, ovf, und}, 0);
    @(posedge clk);
    #1;
    repeat (8) cyc();

    // Single-entry corners from the table.
    for (int i = 0; i < 12; i++) begin
      b.in_write   = vec[i].wr;
      b.in_data    = vec[i].dat;
      b.out_strobe = vec[i].os;
      flush        = vec[i].fl;
      cyc();
      chk($sformatf("vec%0d_out_write", i), b.out_write, vec[i].e_ow);
      chk($sformatf("vec%0d_out_data", i),  b.out_data,  vec[i].e_dat);
      chk($sformatf("vec%0d_level", i),     32'(lvl),    vec[i].e_lvl);
      chk($sformatf("vec%0d_underrun", i),  und,         vec[i].e_und);
    end
    idle();

    // Fill to DEPTH, then one push too many.
    for (int i = 0; i < 64; i++) begin
      b.in_write = 1'b1;
      b.in_data  = 16'(i);
      cyc();
      if (i == 46) chk("afull_after_47", afull, 0);
      if (i == 47) chk("afull_after_48", afull, 1);
      if (i == 62) chk("in_strobe_after_63", b.in_strobe, 1);
      if (i == 63) chk("in_strobe_after_64", b.in_strobe, 0);
    end
    b.in_data = 16'h0040;
    cyc();
    chk("ovf_push65", ovf, 1);
    chk("level_push65", 32'(lvl), 64);
    b.in_write   = 1'b0;
    b.out_strobe = 1'b1;
    for (int i = 0; i < 64; i++) begin
      chk("drain_order", b.out_data, 16'(i));
      cyc();
    end
    idle();
    chk("drain_empty", 32'(lvl), 0);

    // Flush at level 20 with overflow still set.
    for (int i = 0; i < 20; i++) begin
      b.in_write = 1'b1;
      b.in_data  = 16'(100 + i);
      cyc();
    end
    chk("pre_flush_level", 32'(lvl), 20);
    chk("pre_flush_ovf", ovf, 1);
    flush        = 1'b1;
    b.in_data    = 16'hDEAD;
    b.out_strobe = 1'b1;
    cyc();
    chk("flush_level", 32'(lvl), 0);
    chk("flush_out_write", b.out_write, 0);
    chk("flush_ovf", ovf, 0);
    flush        = 1'b0;
    b.out_strobe = 1'b0;
    b.in_data    = 16'hCAFE;
    cyc();
    chk("post_flush_head", b.out_data, 16'hCAFE);
    chk("post_flush_level", 32'(lvl), 1);
    b.in_write   = 1'b0;
    b.out_strobe = 1'b1;
    cyc();
    idle();

    // Steady push+pop at level 3 across pointer wrap.
    for (int i = 0; i < 3; i++) begin
      b.in_write = 1'b1;
      b.in_data  = 16'(1000 + i);
      cyc();
    end
    b.out_strobe = 1'b1;
    for (int i = 0; i < 200; i++) begin
      b.in_data = 16'(2000 + i);
      cyc();
      if (i < 197) chk("stream_head", b.out_data, 16'(i < 2 ? 1001 + i : 2000 + i - 2));
    end
    chk("stream_level", 32'(lvl), 3);
    b.in_write = 1'b0;
    repeat (3) cyc();
    idle();

    // Async reset mid-burst.
    for (int i = 0; i < 10; i++) begin
      b.in_write = 1'b1;
      b.in_data  = 16'(3000 + i);
      cyc();
    end
    b.in_data = 16'h3100;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_level", 32'(lvl), 0);
    chk("arst_out_write", b.out_write, 0);
    chk("arst_in_strobe", b.in_strobe, 1);
    chk("arst_out_data", b.out_data, 0);
    m_reset();
    #2 reset_n = 1'b1;
    b.in_data = 16'h5A5A;
    cyc();
    chk("arst_first_push", b.out_data, 16'h5A5A);
    b.in_write   = 1'b0;
    b.out_strobe = 1'b1;
    cyc();
    idle();

    // Zero-fill build, DEPTH 4.
    chk("z_rst_data", z.out_data, 0);
    z.in_write = 1'b1;
    z.in_data  = 16'h0011;
    zcyc();
    chk("z_first", z.out_data, 16'h0011);
    for (int i = 2; i <= 4; i++) begin
      z.in_data = 16'(i * 16'h0011);
      zcyc();
    end
    chk("z_full_level", 32'(zlvl), 4);
    chk("z_full_in_strobe", z.in_strobe, 0);
    chk("z_afull", zafull, 1);
    z.in_write   = 1'b0;
    z.out_strobe = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      zcyc();
      chk("z_pop_data", z.out_data, 16'(i * 16'h0011));
    end
    zcyc();
    chk("z_empty_out_write", z.out_write, 0);
    chk("z_empty_data", z.out_data, 0);
    zcyc();
    chk("z_underrun", zund, 1);
    chk("z_underrun_data", z.out_data, 0);
    z.out_strobe = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
